// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one fixed-latency memory port between an I-cache fill requester
// (read only) and a D-cache requester (read/write). One transaction is in
// flight at a time: IDLE -> ISSUE (command cycle) -> WAIT (LAT cycles) -> DONE.
// D normally wins contention; a saturating streak counter forces an I grant
// after STARVE consecutive D grants taken while I was waiting.
// Every output is a flop that is loaded from the same next-state decode that
// advances the FSM, so outputs line up exactly with the state they belong to.

module mem_arbiter #(
  parameter int LAT    = 4,  // memory latency in cycles, 2..15
  parameter int STARVE = 3   // max consecutive D grants while I waits, 1..7
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache side
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  // D-cache side
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  // memory side
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  // status
  output logic        busy
);

  // The WAIT counter starts at LAT-1 in the first WAIT cycle and exits at 0,
  // giving exactly LAT WAIT cycles (C+1 .. C+LAT).
  localparam logic [3:0] LAT_LOAD   = 4'(LAT - 1);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      nextState_s;

  logic        arbOpen_s;
  logic        grantI_s;
  logic        grantD_s;
  logic        waitDone_s;

  logic [2:0]  streak_r;
  logic [2:0]  streakNext_s;
  logic [3:0]  latCnt_r;
  logic [3:0]  latCntNext_s;

  // Latched transaction attributes (owner 0 = I, 1 = D)
  logic        ownerD_r;
  logic        wr_r;

  logic        memRd_r;
  logic        memWr_r;
  logic [15:0] memAddr_r;
  logic [15:0] memWdata_r;
  logic [15:0] iRdata_r;
  logic [15:0] dRdata_r;
  logic        iDone_r;
  logic        dDone_r;
  logic        busy_r;

  // Arbitration: allowed in IDLE and DONE; D wins unless I has starved long enough
  always_comb begin
    arbOpen_s = (state_r == IDLE) || (state_r == DONE);
    grantI_s  = 1'b0;
    grantD_s  = 1'b0;
    if (arbOpen_s) begin
      if (d_req && !(i_req && (streak_r == STARVE_MAX))) begin
        grantD_s = 1'b1;
      end else if (i_req) begin
        grantI_s = 1'b1;
      end else begin
        grantI_s = 1'b0;
        grantD_s = 1'b0;
      end
    end else begin
      grantI_s = 1'b0;
      grantD_s = 1'b0;
    end
  end

  // Last WAIT cycle: memory data is valid on mem_rdata this cycle
  always_comb begin
    waitDone_s = (state_r == WAIT) && (latCnt_r == 4'd0);
  end

  // Next-state decode
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (grantI_s || grantD_s) begin
          nextState_s = ISSUE;
        end else begin
          nextState_s = IDLE;
        end
      end
      ISSUE: begin
        nextState_s = WAIT;
      end
      WAIT: begin
        if (latCnt_r == 4'd0) begin
          nextState_s = DONE;
        end else begin
          nextState_s = WAIT;
        end
      end
      DONE: begin
        if (grantI_s || grantD_s) begin
          nextState_s = ISSUE;
        end else begin
          nextState_s = IDLE;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Streak and latency counter next values
  always_comb begin
    streakNext_s = streak_r;
    latCntNext_s = latCnt_r;

    if (grantI_s) begin
      streakNext_s = 3'd0;
    end else if (grantD_s) begin
      if (!i_req) begin
        streakNext_s = 3'd0;
      end else if (streak_r >= STARVE_MAX) begin
        streakNext_s = STARVE_MAX;
      end else begin
        streakNext_s = streak_r + 3'd1;
      end
    end else begin
      streakNext_s = streak_r;
    end

    case (state_r)
      ISSUE: begin
        latCntNext_s = LAT_LOAD;
      end
      WAIT: begin
        if (latCnt_r != 4'd0) begin
          latCntNext_s = latCnt_r - 4'd1;
        end else begin
          latCntNext_s = 4'd0;
        end
      end
      default: begin
        latCntNext_s = 4'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Streak and latency counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_r <= 3'd0;
      latCnt_r <= 4'd0;
    end else begin
      streak_r <= streakNext_s;
      latCnt_r <= latCntNext_s;
    end
  end

  // Grant latch and memory command outputs (command is high only in ISSUE)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerD_r   <= 1'b0;
      wr_r       <= 1'b0;
      memRd_r    <= 1'b0;
      memWr_r    <= 1'b0;
      memAddr_r  <= 16'h0000;
      memWdata_r <= 16'h0000;
    end else begin
      memRd_r <= grantI_s || (grantD_s && !d_wr);
      memWr_r <= grantD_s && d_wr;
      if (grantD_s) begin
        ownerD_r   <= 1'b1;
        wr_r       <= d_wr;
        memAddr_r  <= d_addr;
        memWdata_r <= d_wdata;
      end else if (grantI_s) begin
        ownerD_r   <= 1'b0;
        wr_r       <= 1'b0;
        memAddr_r  <= i_addr;
        memWdata_r <= 16'h0000;
      end else begin
        ownerD_r   <= ownerD_r;
        wr_r       <= wr_r;
        memAddr_r  <= memAddr_r;
        memWdata_r <= memWdata_r;
      end
    end
  end

  // Read data capture at the end of C+LAT and done pulses in C+LAT+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iRdata_r <= 16'h0000;
      dRdata_r <= 16'h0000;
      iDone_r  <= 1'b0;
      dDone_r  <= 1'b0;
    end else begin
      iDone_r <= waitDone_s && !ownerD_r;
      dDone_r <= waitDone_s && ownerD_r;
      if (waitDone_s && !ownerD_r) begin
        iRdata_r <= mem_rdata;
      end else if (waitDone_s && ownerD_r && !wr_r) begin
        dRdata_r <= mem_rdata;
      end else begin
        iRdata_r <= iRdata_r;
        dRdata_r <= dRdata_r;
      end
    end
  end

  // Busy flag tracks "next state is not IDLE" so it equals state_r != IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (nextState_s != IDLE);
    end
  end

  assign mem_rd    = memRd_r;
  assign mem_wr    = memWr_r;
  assign mem_addr  = memAddr_r;
  assign mem_wdata = memWdata_r;
  assign i_rdata   = iRdata_r;
  assign d_rdata   = dRdata_r;
  assign i_done    = iDone_r;
  assign d_done    = dDone_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter (LAT=4, STARVE=3). A behavioural memory answers reads
// LAT cycles after the command; a reference model (expected memory contents,
// expected rdata registers and a starvation streak) predicts every result.

module tb_mem_arbiter;

  localparam int LAT    = 4;
  localparam int STARVE = 3;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  mem_arbiter #(.LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  // ---------------- environment: memory device and event logs ----------------
  typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
  typedef struct { int cyc; logic [15:0] data; } ev_t;

  logic [15:0] devMem [0:65535];
  ev_t   pendQ[$];
  cmd_t  cmdQ[$];
  ev_t   iDoneQ[$];
  ev_t   dDoneQ[$];
  int    busyCnt;

  function automatic logic [15:0] initVal(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always @(negedge clk) begin
    cmd_t c;
    ev_t  e;
    if (!rst) begin
      pendQ.delete();
      mem_rdata = 16'h0000;
    end else begin
      if (pendQ.size() > 0 && pendQ[0].cyc + LAT == cyc) begin
        mem_rdata = devMem[pendQ[0].data];
        void'(pendQ.pop_front());
      end else begin
        mem_rdata = 16'($urandom);
      end
      if (mem_rd) begin
        e.cyc = cyc; e.data = mem_addr; pendQ.push_back(e);
      end
      if (mem_wr) devMem[mem_addr] = mem_wdata;
      if (mem_rd || mem_wr) begin
        c.cyc = cyc; c.wr = mem_wr; c.addr = mem_addr; c.wdata = mem_wdata;
        cmdQ.push_back(c);
      end
      if (i_done) begin e.cyc = cyc; e.data = i_rdata; iDoneQ.push_back(e); end
      if (d_done) begin e.cyc = cyc; e.data = d_rdata; dDoneQ.push_back(e); end
      if (busy) busyCnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] refMem [logic [15:0]];
  logic [15:0] mIRdata;
  logic [15:0] mDRdata;
  int          mStreak;

  function automatic logic [15:0] refRead(logic [15:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  function automatic bit modelWinnerIsD(bit iw, bit dw);
    return dw && !(iw && mStreak == STARVE);
  endfunction

  function automatic void modelGrant(bit isD, bit iw);
    if (!isD) mStreak = 0;
    else if (iw) mStreak = (mStreak < STARVE) ? mStreak + 1 : STARVE;
    else mStreak = 0;
  endfunction

  task automatic clearLogs();
    cmdQ.delete(); iDoneQ.delete(); dDoneQ.delete(); busyCnt = 0;
  endtask

  task automatic idleInputs();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idleInputs();
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    nTests++;
    if ({mem_rd, mem_wr, i_done, d_done, busy} !== 5'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_rd, mem_wr, i_done, d_done, busy});
    end
    nTests++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      nFail++; $display("FAIL reset_mem: got addr=%h wdata=%h expected 0000/0000", mem_addr, mem_wdata);
    end
    nTests++;
    if (i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      nFail++; $display("FAIL reset_rdata: got i=%h d=%h expected 0000/0000", i_rdata, d_rdata);
    end
    rst = 1'b1;
    mStreak = 0; mIRdata = 16'h0; mDRdata = 16'h0;
    repeat (2) @(negedge clk);
    nTests++;
    if (busy !== 1'b0) begin
      nFail++; $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_i_read();
    bit got = 0;
    devMem[16'h0040] = 16'h1234; refMem[16'h0040] = 16'h1234;
    clearLogs();
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0040;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (i_done) begin got = 1; i_req = 1'b0; end
    end
    repeat (2) @(negedge clk);
    modelGrant(1'b0, 1'b1); mIRdata = refRead(16'h0040);
    nTests++;
    if (!got || cmdQ.size() != 1 || iDoneQ.size() != 1) begin
      nFail++; $display("FAIL i_read_events: got cmds=%0d idone=%0d expected 1/1", cmdQ.size(), iDoneQ.size());
    end else begin
      nTests++;
      if (cmdQ[0].wr !== 1'b0 || cmdQ[0].addr !== 16'h0040) begin
        nFail++; $display("FAIL i_read_cmd: got wr=%b addr=%h expected 0/0040", cmdQ[0].wr, cmdQ[0].addr);
      end
      nTests++;
      if (iDoneQ[0].cyc - cmdQ[0].cyc != LAT + 1) begin
        nFail++; $display("FAIL i_read_latency: got %0d expected %0d", iDoneQ[0].cyc - cmdQ[0].cyc, LAT + 1);
      end
      nTests++;
      if (iDoneQ[0].data !== mIRdata) begin
        nFail++; $display("FAIL i_read_data: got %h expected %h", iDoneQ[0].data, mIRdata);
      end
    end
    nTests++;
    if (busyCnt != LAT + 2 || dDoneQ.size() != 0) begin
      nFail++; $display("FAIL i_read_busy: got busy=%0d ddone=%0d expected %0d/0", busyCnt, dDoneQ.size(), LAT + 2);
    end
  endtask

  task automatic test_d_write();
    bit got = 0;
    clearLogs();
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (d_done) begin got = 1; d_req = 1'b0; end
    end
    d_wr = 1'b0;
    repeat (2) @(negedge clk);
    modelGrant(1'b1, 1'b0); refMem[16'h0100] = 16'hBEEF;
    nTests++;
    if (!got || cmdQ.size() != 1 || dDoneQ.size() != 1 || iDoneQ.size() != 0) begin
      nFail++; $display("FAIL d_write_events: got cmds=%0d ddone=%0d idone=%0d expected 1/1/0",
                        cmdQ.size(), dDoneQ.size(), iDoneQ.size());
    end else begin
      nTests++;
      if (cmdQ[0].wr !== 1'b1 || cmdQ[0].addr !== 16'h0100 || cmdQ[0].wdata !== 16'hBEEF) begin
        nFail++; $display("FAIL d_write_cmd: got wr=%b addr=%h wdata=%h expected 1/0100/beef",
                          cmdQ[0].wr, cmdQ[0].addr, cmdQ[0].wdata);
      end
      nTests++;
      if (dDoneQ[0].cyc - cmdQ[0].cyc != LAT + 1) begin
        nFail++; $display("FAIL d_write_latency: got %0d expected %0d", dDoneQ[0].cyc - cmdQ[0].cyc, LAT + 1);
      end
    end
    nTests++;
    if (d_rdata !== mDRdata) begin
      nFail++; $display("FAIL d_write_rdata_hold: got %h expected %h", d_rdata, mDRdata);
    end
  endtask

  task automatic test_d_pulse();
    int k;
    clearLogs();
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
    @(negedge clk);
    d_req = 1'b0; d_wr = 1'b1; d_addr = 16'hFFFF; d_wdata = 16'h0BAD;
    for (k = 0; k < 20 && (dDoneQ.size() == 0 || busy); k++) @(negedge clk);
    d_wr = 1'b0;
    modelGrant(1'b1, 1'b0); mDRdata = refRead(16'h0100);
    nTests++;
    if (cmdQ.size() != 1 || dDoneQ.size() != 1) begin
      nFail++; $display("FAIL d_pulse_events: got cmds=%0d ddone=%0d expected 1/1", cmdQ.size(), dDoneQ.size());
    end else begin
      nTests++;
      if (cmdQ[0].wr !== 1'b0 || cmdQ[0].addr !== 16'h0100 || dDoneQ[0].cyc - cmdQ[0].cyc != LAT + 1) begin
        nFail++; $display("FAIL d_pulse_cmd: got wr=%b addr=%h lat=%0d expected 0/0100/%0d",
                          cmdQ[0].wr, cmdQ[0].addr, dDoneQ[0].cyc - cmdQ[0].cyc, LAT + 1);
      end
      nTests++;
      if (dDoneQ[0].data !== mDRdata) begin
        nFail++; $display("FAIL d_pulse_data: got %h expected %h", dDoneQ[0].data, mDRdata);
      end
    end
    nTests++;
    if (busy !== 1'b0) begin
      nFail++; $display("FAIL d_pulse_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_starvation();
    int nCmd = 0;
    int k;
    bit expD [8];
    int nExpI = 0;
    bit spacingOk = 1;
    bit dataOk = 1;
    clearLogs();
    @(negedge clk);
    i_addr = 16'h0200; d_addr = 16'h0300; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (k = 0; k < 100 && nCmd < 8; k++) begin
      @(negedge clk);
      if (mem_rd || mem_wr) nCmd++;
    end
    idleInputs();
    for (k = 0; k < 20 && busy; k++) @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      expD[g] = modelWinnerIsD(1'b1, 1'b1);
      modelGrant(expD[g], 1'b1);
      if (!expD[g]) nExpI++;
    end
    nTests++;
    if (cmdQ.size() != 8) begin
      nFail++; $display("FAIL starve_count: got %0d expected 8", cmdQ.size());
    end else begin
      for (int g = 0; g < 8; g++) begin
        nTests++;
        if ((cmdQ[g].addr == 16'h0300) !== expD[g]) begin
          nFail++; $display("FAIL starve_order[%0d]: got D=%b expected D=%b", g, cmdQ[g].addr == 16'h0300, expD[g]);
        end
        if (g > 0 && cmdQ[g].cyc - cmdQ[g-1].cyc != LAT + 2) spacingOk = 0;
      end
      nTests++;
      if (!spacingOk) begin
        nFail++; $display("FAIL starve_spacing: got gap %0d expected %0d", cmdQ[1].cyc - cmdQ[0].cyc, LAT + 2);
      end
    end
    nTests++;
    if (iDoneQ.size() != nExpI || dDoneQ.size() != 8 - nExpI) begin
      nFail++; $display("FAIL starve_dones: got i=%0d d=%0d expected %0d/%0d",
                        iDoneQ.size(), dDoneQ.size(), nExpI, 8 - nExpI);
    end
    foreach (iDoneQ[j]) if (iDoneQ[j].data !== refRead(16'h0200)) dataOk = 0;
    foreach (dDoneQ[j]) if (dDoneQ[j].data !== refRead(16'h0300)) dataOk = 0;
    nTests++;
    if (!dataOk) begin
      nFail++; $display("FAIL starve_data: got mismatching rdata expected i=%h d=%h", refRead(16'h0200), refRead(16'h0300));
    end
    mIRdata = refRead(16'h0200); mDRdata = refRead(16'h0300);
  endtask

  task automatic test_late_i();
    int nD = 0;
    int nDAfter = 0;
    int expAfter = 0;
    bit gotI = 0;
    int k;
    clearLogs();
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0310; i_addr = 16'h0210;
    for (k = 0; k < 300 && !gotI; k++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 16'h0310) begin
        if (i_req) nDAfter++;
        else begin
          nD++;
          modelGrant(1'b1, 1'b0);
          if (nD == 5) i_req = 1'b1;
        end
      end else if (mem_rd && mem_addr == 16'h0210) begin
        gotI = 1; idleInputs();
      end
    end
    for (k = 0; k < 20 && busy; k++) @(negedge clk);
    while (modelWinnerIsD(1'b1, 1'b1)) begin
      modelGrant(1'b1, 1'b1); expAfter++;
    end
    modelGrant(1'b0, 1'b1);
    nTests++;
    if (!gotI || nDAfter != expAfter) begin
      nFail++; $display("FAIL late_i_grants: got I=%b extraD=%0d expected 1/%0d", gotI, nDAfter, expAfter);
    end
    mIRdata = refRead(16'h0210); mDRdata = refRead(16'h0310);
  endtask

  task automatic test_reset_mid();
    bit sawCmd = 0;
    bit sawDone = 0;
    bit got = 0;
    int k;
    clearLogs();
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0050;
    for (k = 0; k < 10 && !sawCmd; k++) begin
      @(negedge clk);
      if (mem_rd) sawCmd = 1;
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nTests++;
    if ({busy, mem_rd, mem_wr, i_done, d_done} !== 5'b0 || mem_addr !== 16'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      nFail++; $display("FAIL async_reset: got ctrl=%b addr=%h irdata=%h drdata=%h expected 0",
                        {busy, mem_rd, mem_wr, i_done, d_done}, mem_addr, i_rdata, d_rdata);
    end
    idleInputs();
    mStreak = 0; mIRdata = 16'h0; mDRdata = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i_done) sawDone = 1;
    end
    nTests++;
    if (!sawCmd || sawDone || iDoneQ.size() != 0) begin
      nFail++; $display("FAIL reset_abandon: got cmd=%b idone=%b expected 1/0", sawCmd, sawDone || iDoneQ.size() != 0);
    end
    clearLogs();
    i_req = 1'b1;
    for (k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (i_done) begin got = 1; i_req = 1'b0; end
    end
    @(negedge clk);
    modelGrant(1'b0, 1'b1); mIRdata = refRead(16'h0050);
    nTests++;
    if (!got || cmdQ.size() != 1 || iDoneQ.size() != 1) begin
      nFail++; $display("FAIL reset_fresh_events: got cmds=%0d idone=%0d expected 1/1", cmdQ.size(), iDoneQ.size());
    end else begin
      nTests++;
      if (iDoneQ[0].cyc - cmdQ[0].cyc != LAT + 1 || iDoneQ[0].data !== mIRdata) begin
        nFail++; $display("FAIL reset_fresh_read: got lat=%0d data=%h expected %0d/%h",
                          iDoneQ[0].cyc - cmdQ[0].cyc, iDoneQ[0].data, LAT + 1, mIRdata);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int          t;
      logic [15:0] a;
      logic [15:0] wd;
      int          cmdCyc;
      int          doneCyc;
      logic [15:0] dat;
      bit          got;
      got = 0; cmdCyc = -100; doneCyc = 0; dat = 16'h0;
      t  = $urandom_range(0, 2);
      a  = 16'h0400 + 16'($urandom_range(0, 7));
      wd = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      clearLogs();
      @(negedge clk);
      if (t == 0) begin i_req = 1'b1; i_addr = a; end
      else begin d_req = 1'b1; d_wr = (t == 2); d_addr = a; d_wdata = wd; end
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clk);
        if (mem_rd || mem_wr) begin
          cmdCyc = cyc;
          i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
        if ((t == 0 && i_done) || (t != 0 && d_done)) begin
          got = 1; doneCyc = cyc; dat = (t == 0) ? i_rdata : d_rdata;
          idleInputs();
        end
      end
      @(negedge clk);
      modelGrant(t != 0, 1'b0);
      if (t == 0) mIRdata = refRead(a);
      else if (t == 1) mDRdata = refRead(a);
      else refMem[a] = wd;
      nTests++;
      if (!got || doneCyc - cmdCyc != LAT + 1 || cmdQ.size() != 1) begin
        nFail++; $display("FAIL rand_timing[%0d]: got done=%b lat=%0d cmds=%0d expected 1/%0d/1",
                          n, got, doneCyc - cmdCyc, cmdQ.size(), LAT + 1);
      end else begin
        nTests++;
        if (cmdQ[0].addr !== a || cmdQ[0].wr !== (t == 2) || (t == 2 && cmdQ[0].wdata !== wd)) begin
          nFail++; $display("FAIL rand_cmd[%0d]: got addr=%h wr=%b wdata=%h expected %h/%b/%h",
                            n, cmdQ[0].addr, cmdQ[0].wr, cmdQ[0].wdata, a, t == 2, wd);
        end
      end
      nTests++;
      if ((t == 0 && dat !== mIRdata) || (t != 0 && dat !== mDRdata)) begin
        nFail++; $display("FAIL rand_data[%0d]: got %h expected %h", n, dat, (t == 0) ? mIRdata : mDRdata);
      end
      nTests++;
      if ((t == 0 && dDoneQ.size() != 0) || (t != 0 && iDoneQ.size() != 0)) begin
        nFail++; $display("FAIL rand_other_done[%0d]: got i=%0d d=%0d expected only owner", n, iDoneQ.size(), dDoneQ.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    for (int a = 0; a < 65536; a++) devMem[a] = initVal(16'(a));
    clearLogs();
    test_reset();
    test_i_read();
    test_d_write();
    test_d_pulse();
    test_starvation();
    test_late_i();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 4: fixed memory read/write latency in cycles (legal 2..15).
REQ-002 Parameter STARVE, default 3: maximum consecutive D grants while I is waiting (legal 1..7).
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1: asynchronous reset, active-low (0 = reset).
REQ-005 Port i_req  input  1: I-cache miss fill request, read only.
REQ-006 Port i_addr  input  16: I-cache request address.
REQ-007 Port i_done  output  1: one-cycle pulse; I transaction complete, i_rdata valid.
REQ-008 Port i_rdata  output  16: I fill data.
REQ-009 Port d_req  input  1: D-cache request.
REQ-010 Port d_wr  input  1: D request type; 1 = write, 0 = read.
REQ-011 Port d_addr  input  16: D request address.
REQ-012 Port d_wdata  input  16: D write data.
REQ-013 Port d_done  output  1: one-cycle pulse; D transaction complete, d_rdata valid on reads.
REQ-014 Port d_rdata  output  16: D read data.
REQ-015 Port mem_rd  output  1: memory read command.
REQ-016 Port mem_wr  output  1: memory write command.
REQ-017 Port mem_addr  output  16: memory address.
REQ-018 Port mem_wdata  output  16: memory write data.
REQ-019 Port mem_rdata  input  16: memory read data, valid LAT cycles after the command cycle.
REQ-020 Port busy  output  1: high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; one transaction in flight at a time.
REQ-022 IDLE: a request sampled at a posedge moves the FSM to ISSUE and latches owner, addr, wr and wdata; no request keeps IDLE.
REQ-023 Arbitration: D beats I when both requesters are high, unless the streak counter equals STARVE, in which case I wins.
REQ-024 Streak counter: +1 on each D grant while i_req is high; cleared on any I grant, or on a D grant while i_req is low; never exceeds STARVE.
REQ-025 ISSUE: lasts exactly one cycle (command cycle C); mem_rd or mem_wr is high per the owner and type; mem_addr and mem_wdata are driven from latched values.
REQ-026 mem_rd and mem_wr are never high together, and are 0 outside ISSUE.
REQ-027 WAIT: a 4-bit down-counter loaded with LAT-1 at C; the FSM leaves WAIT when the counter reaches 0, at the end of cycle C+LAT.
REQ-028 mem_rdata is captured at the end of cycle C+LAT into the owner's rdata register; the other rdata register holds its value.
REQ-029 DONE: lasts one cycle (C+LAT+1); the owner's done is high, the other done is low.
REQ-030 DONE also acts as IDLE for arbitration, so the next command cycle is at earliest C+LAT+2.
REQ-031 A D write pulses d_done at C+LAT+1 and leaves d_rdata unchanged.
REQ-032 A requester holds req and its inputs until its done; inputs changing after the latch are ignored.
REQ-033 req dropped mid-transaction: the transaction still completes and done still pulses.
REQ-034 A requester's req sampled high in its own DONE cycle is treated as a new request.
REQ-035 busy is high in ISSUE, WAIT and DONE.

Reset
REQ-036 rst low forces state IDLE immediately, regardless of clk.
REQ-037 During reset: streak and latency counters 0, owner I, all done/mem_rd/mem_wr/busy 0, i_rdata/d_rdata/mem_addr/mem_wdata 0x0000.
REQ-038 Reset mid-transaction abandons it with no done pulse; mem_rdata arriving after reset is ignored.
REQ-039 The first arbitration happens at the first posedge after rst goes high.

Verification (LAT=4, STARVE=3)
REQ-040 i_req=1, i_addr=0x0040, mem returns 0x1234 at C+4 -> mem_rd=1 only at C; i_done=1 and i_rdata=0x1234 at C+5; busy for cycles C..C+5.
REQ-041 d_req=1, d_wr=1, d_addr=0x0100, d_wdata=0xBEEF -> mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF at C; d_done at C+5; d_rdata unchanged.
REQ-042 i_req and d_req high together, held continuously -> grant order D,D,D,I,D,D,D,I; command cycles spaced 6 cycles apart.
REQ-043 d_req pulsed for one cycle, then dropped -> the transaction completes and d_done pulses once at C+5; then the FSM returns to IDLE.
REQ-044 rst driven low asynchronously at C+2 of an I read -> outputs 0 immediately; no i_done; a new I request after release gets a fresh command cycle.
REQ-045 d_req held with i_req=0 -> streak stays 0; i_req raised later is granted after at most 3 further D grants.
